// File: rtl/native_bus_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | native_bus_pkg: shared types for the native memory-port arbiter.      |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
package native_bus_pkg;

  localparam int NATIVE_ADDR_W = 32;
  localparam int NATIVE_DATA_W = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BUSY0 = 2'd1,
    BUSY1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic                     rw;
    logic [NATIVE_ADDR_W-1:0] addr;
    logic [NATIVE_DATA_W-1:0] wrdata;
  } native_req_t;

endpackage
`default_nettype wire

// File: rtl/native_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | native_rr_pick: combinational two-way round-robin chooser.            |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module native_rr_pick (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       any,
  output logic       winner
);

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any    = |req;
    winner = req[1] & (~req[0] | ~last_grant);
  end

endmodule
`default_nettype wire

// File: rtl/native_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | native_mem_arbiter: fetch/LSU round-robin arbiter with bus timeout.   |
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module native_mem_arbiter
  import native_bus_pkg::*;
#(
  parameter int ADDR_W         = NATIVE_ADDR_W,
  parameter int DATA_W         = NATIVE_DATA_W,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int CNT_W          = 11
) (
  input  logic              aclk,
  input  logic              reset,
  input  logic              s0_valid,
  input  logic              s0_rw,
  input  logic [ADDR_W-1:0] s0_addr,
  input  logic [DATA_W-1:0] s0_wrdata,
  output logic              s0_ready,
  output logic              s0_err,
  input  logic              s1_valid,
  input  logic              s1_rw,
  input  logic [ADDR_W-1:0] s1_addr,
  input  logic [DATA_W-1:0] s1_wrdata,
  output logic              s1_ready,
  output logic              s1_err,
  output logic [DATA_W-1:0] s_rdata,
  output logic              m_valid,
  output logic              m_rw,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wrdata,
  input  logic              m_ready,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              grant_id
);

  localparam bit             c_TO_EN       = (TIMEOUT_CYCLES > 0);
  localparam int             c_TO_LAST_INT = (TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0;
  localparam logic [CNT_W-1:0] c_TO_LAST   = c_TO_LAST_INT[CNT_W-1:0];
  localparam logic [CNT_W-1:0] c_CNT_MAX   = '1;

  arb_state_t       r_state;
  arb_state_t       w_state_nxt;
  native_req_t      r_req;
  native_req_t      w_win_req;
  logic             r_last_grant;
  logic             r_grant_id;
  logic [CNT_W-1:0] r_cnt;
  logic             w_any;
  logic             w_winner;
  logic             w_timeout;

  native_rr_pick u_pick (
    .req        ({s1_valid, s0_valid}),
    .last_grant (r_last_grant),
    .any        (w_any),
    .winner     (w_winner)
  );

  always_comb begin
    w_win_req.rw     = w_winner ? s1_rw     : s0_rw;
    w_win_req.addr   = w_winner ? s1_addr   : s0_addr;
    w_win_req.wrdata = w_winner ? s1_wrdata : s0_wrdata;
  end

  // Only evaluated in BUSY states; m_ready on the final cycle takes priority.
  assign w_timeout = c_TO_EN && !m_ready && (r_cnt == c_TO_LAST);

  always_ff @(posedge aclk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE:         if (w_any) w_state_nxt = w_winner ? BUSY1 : BUSY0;
      BUSY0, BUSY1: if (m_ready || w_timeout) w_state_nxt = IDLE;
      default:      w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    m_valid  = 1'b0;
    s0_ready = 1'b0;
    s1_ready = 1'b0;
    s0_err   = 1'b0;
    s1_err   = 1'b0;
    unique case (r_state)
      BUSY0: begin
        m_valid  = 1'b1;
        s0_ready = m_ready | w_timeout;
        s0_err   = w_timeout;
      end
      BUSY1: begin
        m_valid  = 1'b1;
        s1_ready = m_ready | w_timeout;
        s1_err   = w_timeout;
      end
      default: ;
    endcase
  end

  // Request latch and stall counter; the counter saturates rather than wrapping.
  always_ff @(posedge aclk) begin
    if (reset) begin
      r_req        <= '0;
      r_last_grant <= 1'b1;
      r_grant_id   <= 1'b0;
      r_cnt        <= '0;
    end else if (r_state == IDLE) begin
      if (w_any) begin
        r_req        <= w_win_req;
        r_last_grant <= w_winner;
        r_grant_id   <= w_winner;
        r_cnt        <= '0;
      end
    end else if (!m_ready && (r_cnt != c_CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign m_rw     = r_req.rw;
  assign m_addr   = r_req.addr;
  assign m_wrdata = r_req.wrdata;
  assign s_rdata  = m_rdata;
  assign grant_id = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_native_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_native_mem_arbiter: scoreboard bench with a transaction-level model.|
// | Revision: 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_native_mem_arbiter;

  localparam int TO = 8;

  typedef struct {
    bit        rw;
    bit [31:0] addr;
    bit [31:0] wrdata;
    int        gap;
    bit        wiggle;
  } req_t;
  typedef struct { logic id; logic rw; logic [31:0] addr; logic [31:0] wrdata; } grant_t;
  typedef struct { logic id; logic err; logic [31:0] rdata; } resp_t;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        s0_valid, s0_rw, s0_ready, s0_err;
  logic        s1_valid, s1_rw, s1_ready, s1_err;
  logic [31:0] s0_addr, s0_wrdata, s1_addr, s1_wrdata, s_rdata;
  logic        m_valid, m_rw, m_ready, grant_id;
  logic [31:0] m_addr, m_wrdata, m_rdata;

  logic        dv_valid [2];
  logic        dv_rw    [2];
  logic [31:0] dv_addr  [2];
  logic [31:0] dv_wrdata[2];
  logic        done_f   [2];

  assign s0_valid = dv_valid[0];  assign s1_valid = dv_valid[1];
  assign s0_rw    = dv_rw[0];     assign s1_rw    = dv_rw[1];
  assign s0_addr  = dv_addr[0];   assign s1_addr  = dv_addr[1];
  assign s0_wrdata = dv_wrdata[0]; assign s1_wrdata = dv_wrdata[1];

  native_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(TO), .CNT_W(4)) dut (
    .aclk(aclk), .reset(reset),
    .s0_valid(s0_valid), .s0_rw(s0_rw), .s0_addr(s0_addr), .s0_wrdata(s0_wrdata),
    .s0_ready(s0_ready), .s0_err(s0_err),
    .s1_valid(s1_valid), .s1_rw(s1_rw), .s1_addr(s1_addr), .s1_wrdata(s1_wrdata),
    .s1_ready(s1_ready), .s1_err(s1_err),
    .s_rdata(s_rdata),
    .m_valid(m_valid), .m_rw(m_rw), .m_addr(m_addr), .m_wrdata(m_wrdata),
    .m_ready(m_ready), .m_rdata(m_rdata), .grant_id(grant_id)
  );

  always #5 aclk = ~aclk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic fail(input string nm);
    checks++;
    errors++;
    $display("FAIL %s at %0t", nm, $time);
  endtask

  req_t q0[$];
  req_t q1[$];

  task automatic push(input int id, input bit rw, input bit [31:0] a, input bit [31:0] d,
                      input int gap, input bit wig);
    req_t r;
    r.rw = rw; r.addr = a; r.wrdata = d; r.gap = gap; r.wiggle = wig;
    if (id == 0) q0.push_back(r);
    else         q1.push_back(r);
  endtask

  // Requesters: hold valid until ready, optionally disturb addr/wrdata mid-request.
  initial begin : drivers
    req_t cr[2];
    int   held[2];
    int   gap[2];
    for (int i = 0; i < 2; i++) begin
      dv_valid[i] = 0; dv_rw[i] = 0; dv_addr[i] = 0; dv_wrdata[i] = 0;
      held[i] = 0; gap[i] = 0;
    end
    forever begin
      @(posedge aclk); #1;
      for (int id = 0; id < 2; id++) begin
        if (dv_valid[id] && done_f[id]) begin
          dv_valid[id] = 0;
          gap[id] = cr[id].gap;
        end else if (dv_valid[id]) begin
          held[id]++;
          if (cr[id].wiggle && held[id] == 2) begin
            dv_addr[id]   = cr[id].addr + 32'h100;
            dv_wrdata[id] = ~cr[id].wrdata;
          end
        end
        if (!dv_valid[id]) begin
          if (gap[id] > 0) gap[id]--;
          else if ((id == 0 && q0.size() != 0) || (id == 1 && q1.size() != 0)) begin
            if (id == 0) cr[id] = q0.pop_front();
            else         cr[id] = q1.pop_front();
            dv_valid[id] = 1; dv_rw[id] = cr[id].rw;
            dv_addr[id] = cr[id].addr; dv_wrdata[id] = cr[id].wrdata;
            held[id] = 0;
          end
        end
      end
    end
  end

  always @(negedge aclk) begin
    done_f[0] = s0_ready;
    done_f[1] = s1_ready;
  end

  // Bridge: responds br_lat cycles after m_valid rises unless stalled.
  int          br_min = 1, br_max = 1;
  bit          br_stall = 0, br_noise = 0, br_fix = 0;
  logic [31:0] br_val = 32'h0;

  initial begin : bridge
    bit act;
    int cnt, lat;
    m_ready = 0; m_rdata = 0; act = 0; cnt = 0; lat = 0;
    forever begin
      @(posedge aclk); #1;
      if (m_valid) begin
        if (!act) begin
          act = 1; cnt = 0; lat = int'($urandom_range(br_max, br_min));
        end else cnt++;
        m_ready = !br_stall && (cnt == lat);
        m_rdata = br_fix ? br_val : $urandom;
      end else begin
        act = 0;
        m_ready = br_noise && ($urandom_range(3, 0) == 0);
        m_rdata = $urandom;
      end
    end
  end

  // Reference model: whole-transaction view of the arbitration rules.
  grant_t grant_q[$];
  resp_t  resp_q[$];
  bit     mdl_busy = 0, mdl_owner = 0, mdl_last = 1, exp_mvalid = 0;
  int     mdl_len = 0;

  always @(negedge aclk) begin : model
    bit     done;
    grant_t g;
    resp_t  r;
    done = 0;
    exp_mvalid = mdl_busy;
    if (mdl_busy) begin
      mdl_len++;
      if (m_ready) begin
        r.id = mdl_owner; r.err = 0; r.rdata = m_rdata; resp_q.push_back(r); done = 1;
      end else if (mdl_len == TO) begin
        r.id = mdl_owner; r.err = 1; r.rdata = '0; resp_q.push_back(r); done = 1;
      end
    end
    if (reset) begin
      mdl_busy = 0; mdl_last = 1;
    end else if (done) begin
      mdl_busy = 0;
    end else if (!mdl_busy && (s0_valid || s1_valid)) begin
      if (s0_valid && s1_valid) g.id = ~mdl_last;
      else                      g.id = s1_valid;
      g.rw     = g.id ? s1_rw     : s0_rw;
      g.addr   = g.id ? s1_addr   : s0_addr;
      g.wrdata = g.id ? s1_wrdata : s0_wrdata;
      grant_q.push_back(g);
      mdl_busy = 1; mdl_len = 0; mdl_owner = g.id; mdl_last = g.id;
    end
  end

  // Monitor: pops expectations whenever the DUT presents a grant or a completion.
  bit     mon_en = 0, prev_mv = 0;
  grant_t cur;
  int     s0_err_seen = 0;

  always @(negedge aclk) begin : monitor
    resp_t r;
    #1;
    if (mon_en) begin
      check("m_valid", m_valid, exp_mvalid);
      if (m_valid && !prev_mv) begin
        if (grant_q.size() == 0) fail("unexpected grant");
        else begin
          cur = grant_q.pop_front();
          check("grant_id", grant_id, cur.id);
        end
      end
      if (m_valid) begin
        check("m_rw", m_rw, cur.rw);
        check("m_addr", m_addr, cur.addr);
        check("m_wrdata", m_wrdata, cur.wrdata);
      end
      if (s0_ready || s1_ready) begin
        if (s0_ready && s1_ready) fail("both ready");
        else if (resp_q.size() == 0) fail("unexpected ready");
        else begin
          r = resp_q.pop_front();
          check("ready_owner", s1_ready, r.id);
          check("owner_err", r.id ? s1_err : s0_err, r.err);
          check("other_err", r.id ? s0_err : s1_err, 0);
          if (!r.err) check("s_rdata", s_rdata, r.rdata);
          if (s0_err) s0_err_seen++;
        end
      end else begin
        if (s0_err || s1_err) fail("err without ready");
        if (resp_q.size() != 0) begin
          r = resp_q.pop_front();
          fail("missing ready");
        end
      end
      prev_mv = m_valid;
    end
  end

  task automatic drain();
    int n;
    n = 0;
    do begin
      @(negedge aclk); n++;
    end while (!(q0.size() == 0 && q1.size() == 0 && !dv_valid[0] && !dv_valid[1] && !m_valid)
               && n < 3000);
    if (n >= 3000) fail("drain timeout");
    repeat (2) @(negedge aclk);
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin : main
    int n;
    repeat (3) @(posedge aclk);
    @(negedge aclk);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_rw", m_rw, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wrdata", m_wrdata, 0);
    check("rst_grant_id", grant_id, 0);
    check("rst_ready", {s0_ready, s1_ready}, 0);
    check("rst_err", {s0_err, s1_err}, 0);
    @(posedge aclk); #1;
    reset = 0;
    mon_en = 1;
    @(negedge aclk);

    // simultaneous requests right after reset: s0 then s1
    br_min = 2; br_max = 2;
    push(0, 0, 32'h200, 32'h0, 0, 0);
    push(1, 1, 32'h300, 32'h1234_5678, 0, 0);
    drain();

    // lone fetch with fixed read data and 3-cycle latency
    br_fix = 1; br_val = 32'hDEAD_BEEF; br_min = 3; br_max = 3;
    push(0, 0, 32'h100, 32'h0, 0, 0);
    drain();
    br_fix = 0;

    // continuous contention, latency 1
    br_min = 1; br_max = 1;
    for (int i = 0; i < 4; i++) begin
      push(0, 0, 32'h1000 + 32'(i * 4), 32'h0, 0, 0);
      push(1, 1, 32'h2000 + 32'(i * 4), $urandom, 0, 0);
    end
    drain();

    // s1 disturbs its address mid-grant
    br_min = 5; br_max = 5;
    push(1, 1, 32'h400, 32'hCAFE_0001, 0, 0);
    q1[0].wiggle = 1;
    drain();

    // timeout on s0 with s1 pending
    br_stall = 1; br_min = 3; br_max = 3;
    push(0, 0, 32'h600, 32'h0, 0, 0);
    push(1, 1, 32'h700, 32'h7777_0000, 0, 0);
    n = 0;
    while (!s0_err && n < 100) begin @(negedge aclk); n++; end
    check("timeout_s0_err", s0_err, 1);
    check("timeout_s0_ready", s0_ready, 1);
    br_stall = 0;
    drain();
    check("timeout_err_count", s0_err_seen, 1);

    // reset during s1's grant; s0 must win the next tie
    br_min = 1; br_max = 1;
    push(0, 0, 32'h800, 32'h0, 0, 0);
    drain();
    br_stall = 1;
    push(0, 0, 32'h900, 32'h0, 0, 0);
    push(1, 1, 32'hA00, 32'hA5A5_A5A5, 0, 0);
    n = 0;
    do begin @(negedge aclk); n++; end while (!m_valid && n < 50);
    check("pre_reset_owner", grant_id, 1);
    @(posedge aclk); #1;
    reset = 1;
    repeat (2) @(posedge aclk);
    #1;
    reset = 0;
    br_stall = 0;
    drain();

    // randomized traffic, latencies spanning the timeout boundary, noise in IDLE
    br_min = 0; br_max = 9; br_noise = 1;
    for (int i = 0; i < 30; i++) begin
      push(0, 1'($urandom), $urandom, $urandom, int'($urandom_range(3, 0)), 1'($urandom_range(3, 0) == 0));
      push(1, 1'($urandom), $urandom, $urandom, int'($urandom_range(3, 0)), 1'($urandom_range(3, 0) == 0));
    end
    drain();
    br_noise = 0;

    check("grant_q_empty", grant_q.size(), 0);
    check("resp_q_empty", resp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/native_mem_arbiter.md
Name: native_mem_arbiter

Overview:
- Two-requester arbiter for the single native RISC-V memory port that drives the native-to-AXI-Lite bridge.
- Requester 0 is instruction fetch; requester 1 is the load/store unit.
- Grants one whole transaction at a time, with round-robin fairness.
- Latches the request fields for the duration of the grant and aborts a transaction that stalls for too long (bus timeout).

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, read/write data width.
- TIMEOUT_CYCLES, 1024, cycles in a BUSY state without m_ready before an abort; 0 disables the timeout.
- CNT_W, 11, timeout counter width; must satisfy CNT_W >= clog2(TIMEOUT_CYCLES+1).

Ports:
- aclk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- s0_valid  in  1  fetch request.
- s0_rw  in  1  0 = read, 1 = write.
- s0_addr  in  ADDR_W  fetch address.
- s0_wrdata  in  DATA_W  fetch write data (normally unused).
- s0_ready  out  1  fetch transaction complete.
- s0_err  out  1  fetch transaction aborted by timeout.
- s1_valid, s1_rw, s1_addr, s1_wrdata, s1_ready, s1_err  same as the s0 ports, for the LSU.
- s_rdata  out  DATA_W  read data shared by both requesters; qualified by sN_ready.
- m_valid  out  1  request to the bridge.
- m_rw  out  1  to the bridge.
- m_addr  out  ADDR_W  to the bridge.
- m_wrdata  out  DATA_W  to the bridge.
- m_ready  in  1  bridge completion.
- m_rdata  in  DATA_W  bridge read data.
- grant_id  out  1  owner of the current or last grant (debug).

Behaviour:
- Reset values:
  - state = IDLE.
  - m_valid = 0; m_rw = 0; m_addr = 0; m_wrdata = 0.
  - last_grant = 1, so requester 0 wins the first tie.
  - grant_id = 0; timeout counter = 0.
  - sN_ready = 0; sN_err = 0.
- Reset mid-transaction: m_valid drops on the cycle after reset is sampled. No ready or err is issued. The bridge clears its internal done flags when it sees !valid.
- States: IDLE, BUSY0, BUSY1.
- IDLE transitions:
  - Only s0_valid: go to BUSY0.
  - Only s1_valid: go to BUSY1.
  - Both valid: grant the requester != last_grant.
  - Neither valid: stay in IDLE.
- On the grant edge:
  - Register rw, addr and wrdata of the winner into m_rw, m_addr and m_wrdata.
  - Set last_grant = winner, grant_id = winner, timeout counter = 0.
- Latency: request sampled at edge k gives m_valid = 1 in the cycle after edge k. There is no combinational path from sN_* to m_*.
- BUSY0/BUSY1 outputs:
  - m_valid = 1.
  - m_* are stable (latched values) for the whole grant.
  - The counter increments every cycle without m_ready.
- BUSY completion:
  - When m_ready = 1, the owner's sN_ready = 1 in that same cycle (combinational: m_ready & busy & owner).
  - s_rdata = m_rdata (combinational pass-through).
  - Next state is IDLE; m_valid = 0 for at least one cycle between transactions.
- Non-owner: sN_ready = 0 and sN_err = 0 always.
- Timeout (TIMEOUT_CYCLES > 0): when the counter equals TIMEOUT_CYCLES-1 and m_ready = 0:
  - Owner's sN_err = 1 and sN_ready = 1 for one cycle; s_rdata is undefined.
  - Next state is IDLE and m_valid drops.
- m_ready and timeout on the same cycle: m_ready wins; err = 0.
- Requester drops valid while owning a grant: the transaction still completes on the latched fields, and ready pulses anyway. Requesters must hold valid until ready by protocol.
- Requester changes addr/wrdata while granted: no effect.
- m_ready in IDLE: ignored.
- Fairness: with both requesters continuously valid, grants alternate 0, 1, 0, 1, … with one IDLE cycle between them.
- Width rules:
  - The counter saturates; it never wraps.
  - rw, addr and wrdata are passed through with no width change.

Decomposition:
- Package native_bus_pkg holds:
  - typedef arb_state_t {IDLE, BUSY0, BUSY1};
  - localparam NATIVE_ADDR_W = 32, NATIVE_DATA_W = 32;
  - a struct native_req_t {rw, addr, wrdata} used for the latched request.
- One sub-module is natural: native_rr_pick. It is a combinational 2-way round-robin chooser with inputs {req[1:0], last_grant} and outputs {any, winner}.
- The FSM, request latch and timeout counter stay in native_mem_arbiter.

Test Plan:
- Lone fetch: s0 read addr 0x0000_0100; bridge returns m_ready 3 cycles after m_valid with m_rdata 0xDEAD_BEEF → m_valid rises 1 cycle after request, m_addr = 0x100, m_rw = 0, s0_ready pulses once with s_rdata = 0xDEAD_BEEF, s1_ready stays 0.
- Simultaneous requests after reset: s0 read 0x200 and s1 write 0x300 / 0x1234_5678, both held valid → s0 granted first, then one IDLE cycle, then m_addr = 0x300, m_rw = 1, m_wrdata = 0x1234_5678, s1_ready pulses.
- Continuous contention for 8 transactions, bridge latency 1 → grant_id sequence 0, 1, 0, 1, 0, 1, 0, 1; no requester starves.
- Stability: s1 changes s1_addr from 0x400 to 0x500 mid-grant → m_addr holds 0x400 until s1_ready.
- Timeout: TIMEOUT_CYCLES = 8, bridge never asserts m_ready → s0_err = 1 and s0_ready = 1 on the 8th BUSY cycle, m_valid = 0 the next cycle, and a pending s1 is granted afterwards.
- Reset mid-transaction: reset asserted on the 2nd BUSY cycle → m_valid = 0, no ready or err, and the next grant after reset goes to s0 when both requesters are valid.
